ddr_cmd_issuer: RTL
===================

Name: ddr_cmd_issuer

Overview:
- Client-side command initiator for the x32 DDR controller's command decoder.
- Arbitrates one read client, one write client and a mode-register (LMR) request onto the decoder's cmd/cmd_valid/busy interface.
- Holds address stable for the whole transaction and returns per-client grant/done pulses to the frame-write and HDR-read engines.

Parameters:
- ADDR_W, 24, client/DDR address width.
- AUTO_PRE, 1, 1 = issue read/write with auto-precharge (0011/0100); 0 = plain read/write (0001/0010).
- IDLE_TIMEOUT, 1024, idle cycles before power-down entry (optional feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous active-low
- init_done  in  1  controller initialisation complete
- busy  in  1  decoder busy
- cmd  out  4  command code to decoder
- cmd_valid  out  1  command strobe, single cycle
- addr  out  ADDR_W  transaction address
- rd_req / rd_addr  in  1 / ADDR_W  read request and address, level, held until rd_grant
- wr_req / wr_addr  in  1 / ADDR_W  write request and address, same rules
- lmr_req  in  1  mode-register load request, held until lmr_grant
- rd_grant / wr_grant / lmr_grant  out  1  one-cycle pulse, request accepted
- rd_done / wr_done / lmr_done  out  1  one-cycle pulse, controller returned to idle
- pending  out  1  transaction in flight (not in IDLE)

Behaviour:
- Reset (async, rst_n=0): all outputs 0, addr=0, cmd=0000, FSM=IDLE, round-robin pointer = read-first.
- Command codes: 0001 RD, 0010 WR, 0011 RD+AP, 0100 WR+AP, 0101 power-down, 0110 LMR; no other codes are generated.
- FSM states: IDLE, ISSUE, ACCEPT, WAIT_DONE, plus PD_ENTER and PD_WAKE when the optional feature is compiled in.
- IDLE: no command while init_done=0. When init_done=1, busy=0 and at least one request is present, latch the winner and go to ISSUE.
  - Priority: lmr_req highest.
  - rd_req vs wr_req alternates round-robin: pointer flips to the other client after each grant.
  - A lone request wins regardless of the pointer.
- Winner latch: addr <= winner address (LMR: addr <= rd_addr field ignored, 0); cmd <= code; grant pulse asserted in the same cycle.
- ISSUE: cmd_valid=1 for exactly one cycle → ACCEPT.
- ACCEPT: busy=1 → WAIT_DONE. busy=0 → re-enter ISSUE, cmd_valid again; at most 3 retries, then drop to IDLE and raise done anyway (error case, flagged in assertion).
- WAIT_DONE: wait for busy=0. Then pulse the matching done, cmd_valid=0, pending=0 → IDLE. cmd/addr held constant throughout.
- Refresh: if busy rises while in IDLE (controller pre-refresh or refresh), no issue occurs; the request stays pending and is not granted.
- Latency: request seen with busy=0 → cmd_valid 2 cycles later; done 1 cycle after busy falls.
- Simultaneous rd_req, wr_req and lmr_req: LMR first, then read/write per pointer; no request is starved beyond one competing transaction.
- A request dropped before its grant is simply not served.
- init_done falling mid-transaction: finish the current handshake, then hold in IDLE.

Optional Feature:
- Macro DDR_IDLE_PWRDWN_EN.
- Defined: an idle counter increments in IDLE while there are no requests and busy=0, and clears on any request.
  - At IDLE_TIMEOUT, issue 0101 via ISSUE/ACCEPT, then move to PD_ENTER.
  - The first request in PD_ENTER issues a wake command, 0101 with cmd_valid for one cycle, then moves to PD_WAKE. The decoder discards this command.
  - PD_WAKE waits for busy=0, then returns to IDLE, where the real request is arbitrated normally with no grant lost.
- Undefined: counter and PD states are absent; code 0101 is never produced.

Test Plan:
- rd_req=1, rd_addr=0x00ABCD, AUTO_PRE=1, busy low → rd_grant, and cmd=0011/cmd_valid 2 cycles later, addr=0x00ABCD. Drive busy high 8 cycles → rd_done 1 cycle after busy falls.
- rd_req and wr_req both held for 4 transactions → order RD, WR, RD, WR; grant count 2 each.
- lmr_req raised with rd_req → cmd=0110 first; rd_req served after lmr_done.
- busy held high 20 cycles (refresh) while wr_req=1 → no cmd_valid and no wr_grant until busy falls; then cmd=0100 2 cycles after.
- rst_n pulsed low mid-WAIT_DONE → outputs 0 immediately (async), FSM IDLE, no done pulse.
- With DDR_IDLE_PWRDWN_EN, IDLE_TIMEOUT=16: idle 16 cycles → cmd=0101. Then rd_req → wake 0101, busy low → cmd=0011.

Source files
------------

// File: rtl/ddr_cmd_issuer.sv
// ddr_cmd_issuer: arbitrates one read client, one write client and a mode-register
// load request onto the DDR command decoder's cmd/cmd_valid/busy handshake.
// Address and command code are latched at grant and held until the transaction ends.
// Optional idle power-down entry/exit is compiled in with `define DDR_IDLE_PWRDWN_EN.
//
// state     | meaning
// IDLE      | arbitrate requests, nothing in flight
// ISSUE     | command latched, strobe cmd_valid on exit
// ACCEPT    | strobe cycle, then check busy for acceptance (retry if not accepted)
// WAIT_DONE | decoder busy with our command, wait for busy to fall
// PD_ENTER  | power-down command issued, wait for any request (optional)
// PD_WAKE   | wake command issued, wait for busy low (optional)
module ddr_cmd_issuer #(
    parameter int   ADDR_W       = 24,
    parameter logic AUTO_PRE     = 1'b1,
    parameter int   IDLE_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_done,
    input  logic              busy,
    output logic [3:0]        cmd,
    output logic              cmd_valid,
    output logic [ADDR_W-1:0] addr,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              lmr_req,
    output logic              rd_grant,
    output logic              wr_grant,
    output logic              lmr_grant,
    output logic              rd_done,
    output logic              wr_done,
    output logic              lmr_done,
    output logic              pending
);

    localparam logic [3:0] CMD_RD  = AUTO_PRE ? 4'b0011 : 4'b0001;
    localparam logic [3:0] CMD_WR  = AUTO_PRE ? 4'b0100 : 4'b0010;
    localparam logic [3:0] CMD_PD  = 4'b0101;
    localparam logic [3:0] CMD_LMR = 4'b0110;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ACCEPT,
        WAIT_DONE
`ifdef DDR_IDLE_PWRDWN_EN
        ,
        PD_ENTER,
        PD_WAKE
`endif
    } state_t;

    typedef enum logic [1:0] {
        K_RD,
        K_WR,
        K_LMR,
        K_PD
    } kind_t;

    state_t            state, state_nxt;
    kind_t             txn_kind, latch_kind;
    logic              rr_rd_first;
    logic [1:0]        retry_cnt;
    logic              latch, strobe, finish, retry;
    logic [3:0]        latch_cmd;
    logic [ADDR_W-1:0] latch_addr;
    logic              any_req;

    assign any_req = rd_req | wr_req | lmr_req;

`ifdef DDR_IDLE_PWRDWN_EN
    localparam int IDLE_CNT_W = $clog2(IDLE_TIMEOUT + 1);
    logic [IDLE_CNT_W-1:0] idle_cnt;
    logic                  idle_cond;

    assign idle_cond = (state == IDLE) && init_done && !busy && !any_req;

    // Count quiet idle cycles; any request, busy or leaving IDLE restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (idle_cond && !latch) begin
            idle_cnt <= idle_cnt + 1'b1;
        end else begin
            idle_cnt <= '0;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, arbitration and handshake decisions.
    always_comb begin
        state_nxt  = state;
        latch      = 1'b0;
        latch_kind = K_RD;
        latch_cmd  = 4'b0000;
        latch_addr = '0;
        strobe     = 1'b0;
        finish     = 1'b0;
        retry      = 1'b0;
        case (state)
            IDLE: begin
                if (init_done && !busy) begin
                    if (lmr_req) begin
                        latch      = 1'b1;
                        latch_kind = K_LMR;
                        latch_cmd  = CMD_LMR;
                    end else if (rd_req && (!wr_req || rr_rd_first)) begin
                        latch      = 1'b1;
                        latch_kind = K_RD;
                        latch_cmd  = CMD_RD;
                        latch_addr = rd_addr;
                    end else if (wr_req) begin
                        latch      = 1'b1;
                        latch_kind = K_WR;
                        latch_cmd  = CMD_WR;
                        latch_addr = wr_addr;
                    end
`ifdef DDR_IDLE_PWRDWN_EN
                    else if (idle_cnt == IDLE_CNT_W'(IDLE_TIMEOUT - 1)) begin
                        latch      = 1'b1;
                        latch_kind = K_PD;
                        latch_cmd  = CMD_PD;
                    end
`endif
                end
                if (latch) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                strobe    = 1'b1;
                state_nxt = ACCEPT;
            end
            ACCEPT: begin
                // The decoder registers the strobe, so busy is judged the cycle after it.
                if (!cmd_valid) begin
                    if (busy) begin
                        state_nxt = WAIT_DONE;
                    end else if (retry_cnt == 2'd3) begin
                        finish    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        retry     = 1'b1;
                        state_nxt = ISSUE;
                    end
                end
`ifdef DDR_IDLE_PWRDWN_EN
                if (cmd_valid && txn_kind == K_PD) begin
                    state_nxt = PD_ENTER;
                end
`endif
            end
            WAIT_DONE: begin
                if (!busy) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
`ifdef DDR_IDLE_PWRDWN_EN
            PD_ENTER: begin
                if (any_req) begin
                    strobe    = 1'b1;
                    state_nxt = PD_WAKE;
                end
            end
            PD_WAKE: begin
                if (!busy) begin
                    state_nxt = IDLE;
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs, transaction latch and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd         <= 4'b0000;
            cmd_valid   <= 1'b0;
            addr        <= '0;
            rd_grant    <= 1'b0;
            wr_grant    <= 1'b0;
            lmr_grant   <= 1'b0;
            rd_done     <= 1'b0;
            wr_done     <= 1'b0;
            lmr_done    <= 1'b0;
            pending     <= 1'b0;
            txn_kind    <= K_RD;
            retry_cnt   <= 2'd0;
            rr_rd_first <= 1'b1;
        end else begin
            cmd_valid <= strobe;
            rd_grant  <= latch && (latch_kind == K_RD);
            wr_grant  <= latch && (latch_kind == K_WR);
            lmr_grant <= latch && (latch_kind == K_LMR);
            rd_done   <= finish && (txn_kind == K_RD);
            wr_done   <= finish && (txn_kind == K_WR);
            lmr_done  <= finish && (txn_kind == K_LMR);
            pending   <= (state_nxt != IDLE);
            if (latch) begin
                cmd       <= latch_cmd;
                addr      <= latch_addr;
                txn_kind  <= latch_kind;
                retry_cnt <= 2'd0;
            end else if (retry) begin
                retry_cnt <= retry_cnt + 2'd1;
            end
            if (latch && latch_kind == K_RD) begin
                rr_rd_first <= 1'b0;
            end else if (latch && latch_kind == K_WR) begin
                rr_rd_first <= 1'b1;
            end
        end
    end

    // Giving up after the last retry still reports done, but is a decoder protocol error.
    retry_exhausted_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(state == ACCEPT && !cmd_valid && !busy && retry_cnt == 2'd3));

    // A zero timeout would make the idle counter compare meaningless.
    idle_timeout_a: assert property (@(posedge clk) IDLE_TIMEOUT > 0);

endmodule
